frame_bank_scheduler: RTL and testbench

- Sequences frame-buffer bank ownership between the HDMI-side pixel writer and the matrix-side SPI reader.
- Sync_Manager provides I_new_frame and I_image_valid; the writer reports completion with I_frame_done; the reader requests fresh frames with I_rd_req.
- Implements double or triple buffering, so the reader never sees a partially written bank. Counts dropped and aborted frames.

---
 rtl/frame_sched_pkg.sv | 20 ++
 rtl/frame_skip_gate.sv | 27 ++
 rtl/frame_bank_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and bank-selection helper for the frame bank scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    WRITING    = 2'd2,
    BLOCKED    = 2'd3
  } state_t;

  typedef logic [1:0] bank_t;

  // Lowest-index bank that is neither d nor f.
  function automatic bank_t free_bank(input bank_t d, input bank_t f);
    if (d != 2'd0 && f != 2'd0) return 2'd0;
    if (d != 2'd1 && f != 2'd1) return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/frame_skip_gate.sv
// Modulo-SKIP_RATIO input frame counter; a write may start only when the count is zero.
module frame_skip_gate #(
  parameter int unsigned SKIP_RATIO = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  output logic pass
);

  localparam int unsigned CNT_BITS = 4;

  logic [CNT_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (adv) begin
      if (cnt == CNT_BITS'(SKIP_RATIO - 1)) cnt <= '0;
      else                                  cnt <= cnt + CNT_BITS'(1);
    end
  end

  assign pass = (cnt == '0);

endmodule

// File: rtl/frame_bank_scheduler.sv
// Double/triple-buffer bank ownership between the HDMI pixel writer and the SPI matrix reader.
// Optional input-frame decimation is built when FRAME_SKIP_EN is defined.
module frame_bank_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 3,
  parameter int unsigned SKIP_RATIO = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             I_rgb_clk,
  input  logic             I_rst_n,
  input  logic             I_image_valid,
  input  logic             I_new_frame,
  input  logic             I_frame_done,
  input  logic             I_rd_req,
  output logic [1:0]       O_wr_bank,
  output logic             O_wr_enable,
  output logic [1:0]       O_rd_bank,
  output logic             O_rd_valid,
  output logic             O_rd_swap,
  output logic [CNT_W-1:0] O_drop_count,
  output logic [CNT_W-1:0] O_abort_count,
  output logic [1:0]       O_state
);

  if (NUM_BANKS != 2 && NUM_BANKS != 3) begin : g_bad_banks
    $error("frame_bank_scheduler: NUM_BANKS must be 2 or 3");
  end
  if (SKIP_RATIO < 1 || SKIP_RATIO > 15) begin : g_bad_skip
    $error("frame_bank_scheduler: SKIP_RATIO must be 1..15");
  end

  localparam bank_t RST_D = bank_t'(NUM_BANKS - 1);

  state_t           state;
  bank_t            w, d, f;
  logic             f_v;
  logic             wr_enable, rd_valid, rd_swap;
  logic [CNT_W-1:0] drop_cnt, abort_cnt;
  logic             skip_pass;
  logic             rd_take;
  logic             drop_inc;
  logic             commit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign rd_take = I_rd_req && f_v;
  assign commit  = I_image_valid && (state == WRITING) && I_frame_done;

`ifdef FRAME_SKIP_EN
  logic skip_adv;

  // The counter sees every frame that could start a write: in WAIT_FRAME or back-to-back with a commit.
  assign skip_adv = I_image_valid && I_new_frame &&
                    ((state == WAIT_FRAME) || (commit && NUM_BANKS == 3));

  frame_skip_gate #(
    .SKIP_RATIO(SKIP_RATIO)
  ) u_skip_gate (
    .clk  (I_rgb_clk),
    .rst_n(I_rst_n),
    .clr  (!I_image_valid),
    .adv  (skip_adv),
    .pass (skip_pass)
  );
`else
  assign skip_pass = 1'b1;
`endif

  // Frames lost: overwriting an unread fresh bank, or input frames arriving with no free bank.
  always_comb begin
    drop_inc = 1'b0;
    if (I_image_valid) begin
      if (commit)
        drop_inc = (f_v && !I_rd_req) || (NUM_BANKS == 2 && I_new_frame);
      else if (state == BLOCKED)
        drop_inc = I_new_frame;
    end
  end

  always_ff @(posedge I_rgb_clk) begin
    if (!I_rst_n) begin
      state     <= IDLE;
      w         <= 2'd0;
      d         <= RST_D;
      f         <= 2'd0;
      f_v       <= 1'b0;
      wr_enable <= 1'b0;
      rd_valid  <= 1'b0;
      rd_swap   <= 1'b0;
      drop_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      rd_swap <= 1'b0;
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);

      if (!I_image_valid) begin
        // Geometry lost: abandon the write and the fresh frame, keep showing the display bank.
        state     <= IDLE;
        wr_enable <= 1'b0;
        f_v       <= 1'b0;
        w         <= free_bank(d, d);
      end else begin
        unique case (state)
          IDLE: state <= WAIT_FRAME;

          WAIT_FRAME: begin
            if (I_new_frame && skip_pass) begin
              state     <= WRITING;
              wr_enable <= 1'b1;
            end
            if (rd_take) begin
              d        <= f;
              f_v      <= 1'b0;
              rd_valid <= 1'b1;
              rd_swap  <= 1'b1;
            end
          end

          WRITING: begin
            if (I_frame_done) begin
              // Commit first; a same-cycle read takes the just-written bank.
              f         <= w;
              wr_enable <= 1'b0;
              if (I_rd_req) begin
                d        <= w;
                f_v      <= 1'b0;
                rd_valid <= 1'b1;
                rd_swap  <= 1'b1;
              end else begin
                f_v <= 1'b1;
              end
              if (NUM_BANKS == 3) begin
                w <= I_rd_req ? free_bank(w, w) : free_bank(d, w);
                if (I_new_frame && skip_pass) begin
                  state     <= WRITING;
                  wr_enable <= 1'b1;
                end else begin
                  state <= WAIT_FRAME;
                end
              end else if (I_rd_req) begin
                w     <= d;
                state <= WAIT_FRAME;
              end else begin
                state <= BLOCKED;
              end
            end else begin
              if (I_new_frame) abort_cnt <= sat_inc(abort_cnt);
              if (rd_take) begin
                d        <= f;
                f_v      <= 1'b0;
                rd_valid <= 1'b1;
                rd_swap  <= 1'b1;
              end
            end
          end

          BLOCKED: begin
            wr_enable <= 1'b0;
            if (rd_take) begin
              d        <= f;
              w        <= d;
              f_v      <= 1'b0;
              rd_valid <= 1'b1;
              rd_swap  <= 1'b1;
              state    <= WAIT_FRAME;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  // Writer never touches the displayed bank, nor the fresh bank unless no free bank exists.
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst_n) begin
      inv_wd: assert (w != d);
      inv_wf: assert (!(f_v && state != BLOCKED && w == f));
    end
  end

  assign O_wr_bank     = w;
  assign O_wr_enable   = wr_enable;
  assign O_rd_bank     = d;
  assign O_rd_valid    = rd_valid;
  assign O_rd_swap     = rd_swap;
  assign O_drop_count  = drop_cnt;
  assign O_abort_count = abort_cnt;
  assign O_state       = state;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: triple- and double-buffer instances, plus skip mode under FRAME_SKIP_EN.
module tb_frame_bank_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Triple-buffer instance
  logic        iv3, nf3, fd3, rr3;
  logic [1:0]  wb3, rb3, st3;
  logic        we3, rv3, sw3;
  logic [15:0] dc3, ac3;

  frame_bank_scheduler #(.NUM_BANKS(3), .SKIP_RATIO(1), .CNT_W(16)) dut3 (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_image_valid(iv3), .I_new_frame(nf3),
    .I_frame_done(fd3), .I_rd_req(rr3), .O_wr_bank(wb3), .O_wr_enable(we3),
    .O_rd_bank(rb3), .O_rd_valid(rv3), .O_rd_swap(sw3), .O_drop_count(dc3),
    .O_abort_count(ac3), .O_state(st3)
  );

  // Double-buffer instance with 2-bit counters to reach saturation quickly
  logic        iv2, nf2, fd2, rr2;
  logic [1:0]  wb2, rb2, st2;
  logic        we2, rv2, sw2;
  logic [1:0]  dc2, ac2;

  frame_bank_scheduler #(.NUM_BANKS(2), .SKIP_RATIO(1), .CNT_W(2)) dut2 (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_image_valid(iv2), .I_new_frame(nf2),
    .I_frame_done(fd2), .I_rd_req(rr2), .O_wr_bank(wb2), .O_wr_enable(we2),
    .O_rd_bank(rb2), .O_rd_valid(rv2), .O_rd_swap(sw2), .O_drop_count(dc2),
    .O_abort_count(ac2), .O_state(st2)
  );

`ifdef FRAME_SKIP_EN
  logic        ivs, nfs, fds, rrs;
  logic [1:0]  wbs, rbs, sts;
  logic        wes, rvs, sws;
  logic [15:0] dcs, acs;
  int          nswap;

  frame_bank_scheduler #(.NUM_BANKS(3), .SKIP_RATIO(3), .CNT_W(16)) dut_s (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_image_valid(ivs), .I_new_frame(nfs),
    .I_frame_done(fds), .I_rd_req(rrs), .O_wr_bank(wbs), .O_wr_enable(wes),
    .O_rd_bank(rbs), .O_rd_valid(rvs), .O_rd_swap(sws), .O_drop_count(dcs),
    .O_abort_count(acs), .O_state(sts)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv3 = 0; nf3 = 0; fd3 = 0; rr3 = 0;
    iv2 = 0; nf2 = 0; fd2 = 0; rr2 = 0;
`ifdef FRAME_SKIP_EN
    ivs = 0; nfs = 0; fds = 0; rrs = 0; nswap = 0;
`endif
    tick(); tick();

    // Reset state
    chk("rst3_state", 32'(st3), 0);
    chk("rst3_wr_bank", 32'(wb3), 0);
    chk("rst3_rd_bank", 32'(rb3), 2);
    chk("rst3_wr_en", 32'(we3), 0);
    chk("rst3_rd_valid", 32'(rv3), 0);
    chk("rst3_swap", 32'(sw3), 0);
    chk("rst3_drop", 32'(dc3), 0);
    chk("rst3_abort", 32'(ac3), 0);
    chk("rst2_rd_bank", 32'(rb2), 1);
    chk("rst2_wr_bank", 32'(wb2), 0);

    // Plan 1 and 4: first write into bank 0, abort mid-write, commit, read
    rst_n = 1'b1; iv3 = 1;
    tick();
    chk("t1_wait", 32'(st3), 1);
    nf3 = 1; tick(); nf3 = 0;
    chk("t1_writing", 32'(st3), 2);
    chk("t1_wr_bank", 32'(wb3), 0);
    chk("t1_wr_en", 32'(we3), 1);
    repeat (3) tick();
    nf3 = 1; tick(); nf3 = 0;
    chk("t4_abort", 32'(ac3), 1);
    chk("t4_wr_bank", 32'(wb3), 0);
    chk("t4_wr_en", 32'(we3), 1);
    chk("t4_state", 32'(st3), 2);
    repeat (9) tick();
    fd3 = 1; tick(); fd3 = 0;
    chk("t1_commit_wr_bank", 32'(wb3), 1);
    chk("t1_commit_wr_en", 32'(we3), 0);
    chk("t1_commit_state", 32'(st3), 1);
    chk("t1_commit_drop", 32'(dc3), 0);
    rr3 = 1; tick(); rr3 = 0;
    chk("t1_rd_bank", 32'(rb3), 0);
    chk("t1_rd_valid", 32'(rv3), 1);
    chk("t1_swap", 32'(sw3), 1);
    tick();
    chk("t1_swap_one_cycle", 32'(sw3), 0);

    // Plan 2: two commits without a read drop one frame
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    chk("rst_again_abort", 32'(ac3), 0);
    chk("rst_again_rd_valid", 32'(rv3), 0);
    tick();
    nf3 = 1; tick(); nf3 = 0;
    fd3 = 1; tick(); fd3 = 0;
    nf3 = 1; tick(); nf3 = 0;
    fd3 = 1; tick(); fd3 = 0;
    chk("t2_drop", 32'(dc3), 1);
    chk("t2_wr_bank", 32'(wb3), 0);
    rr3 = 1; tick(); rr3 = 0;
    chk("t2_rd_bank", 32'(rb3), 1);
    chk("t2_swap", 32'(sw3), 1);

    // Plan 5: commit and read in the same cycle
    nf3 = 1; tick(); nf3 = 0;
    fd3 = 1; rr3 = 1; tick(); fd3 = 0; rr3 = 0;
    chk("t5_rd_bank", 32'(rb3), 0);
    chk("t5_drop", 32'(dc3), 1);
    chk("t5_wr_bank", 32'(wb3), 1);
    chk("t5_swap", 32'(sw3), 1);
    chk("t5_state", 32'(st3), 1);

    // Commit over an unread fresh bank with a same-cycle read: no drop
    nf3 = 1; tick(); nf3 = 0;
    fd3 = 1; tick(); fd3 = 0;
    nf3 = 1; tick(); nf3 = 0;
    fd3 = 1; rr3 = 1; tick(); fd3 = 0; rr3 = 0;
    chk("t5b_drop", 32'(dc3), 1);
    chk("t5b_rd_bank", 32'(rb3), 2);
    chk("t5b_wr_bank", 32'(wb3), 0);

    // Commit with a same-cycle new frame starts in the new write bank
    nf3 = 1; tick(); nf3 = 0;
    fd3 = 1; nf3 = 1; tick(); fd3 = 0; nf3 = 0;
    chk("t5c_state", 32'(st3), 2);
    chk("t5c_wr_bank", 32'(wb3), 1);
    chk("t5c_wr_en", 32'(we3), 1);
    chk("t5c_abort", 32'(ac3), 0);

    // Image valid falls mid-write
    iv3 = 0; tick();
    chk("t6_idle", 32'(st3), 0);
    chk("t6_wr_en", 32'(we3), 0);
    chk("t6_rd_bank", 32'(rb3), 2);
    chk("t6_rd_valid", 32'(rv3), 1);
    chk("t6_wr_bank", 32'(wb3), 0);
    rr3 = 1; tick(); rr3 = 0;
    chk("t6_no_swap", 32'(sw3), 0);
    chk("t6_rd_bank_kept", 32'(rb3), 2);

    // Plan 3: double buffering blocks until the reader takes the frame
    iv2 = 1; tick();
    chk("t3_wait", 32'(st2), 1);
    nf2 = 1; tick(); nf2 = 0;
    chk("t3_wr_bank", 32'(wb2), 0);
    fd2 = 1; tick(); fd2 = 0;
    chk("t3_blocked", 32'(st2), 3);
    repeat (3) begin
      nf2 = 1; tick(); nf2 = 0;
    end
    chk("t3_drop", 32'(dc2), 3);
    chk("t3_wr_en", 32'(we2), 0);
    chk("t3_state", 32'(st2), 3);
    rr2 = 1; tick(); rr2 = 0;
    chk("t3_rd_bank", 32'(rb2), 0);
    chk("t3_wr_bank_after", 32'(wb2), 1);
    chk("t3_state_after", 32'(st2), 1);
    chk("t3_swap", 32'(sw2), 1);
    nf2 = 1; tick(); nf2 = 0;
    fd2 = 1; nf2 = 1; tick(); fd2 = 0; nf2 = 0;
    chk("t3_sat_drop", 32'(dc2), 3);
    chk("t3_sat_state", 32'(st2), 3);

`ifdef FRAME_SKIP_EN
    // Plan 6: SKIP_RATIO=3 writes one frame in three
    ivs = 1; tick();
    repeat (6) begin
      nfs = 1; tick(); nfs = 0;
      tick();
      fds = 1; tick(); fds = 0;
      rrs = 1; tick(); rrs = 0;
      if (sws) nswap++;
    end
    chk("t6s_commits", 32'(nswap), 2);
    chk("t6s_drop", 32'(dcs), 0);
    chk("t6s_rd_bank", 32'(rbs), 1);
    nfs = 1; tick(); nfs = 0;
    chk("t6s_writing", 32'(sts), 2);
    chk("t6s_wr_bank", 32'(wbs), 2);
    ivs = 0; tick();
    chk("t6s_idle", 32'(sts), 0);
    chk("t6s_rd_kept", 32'(rbs), 1);
    chk("t6s_wr_en", 32'(wes), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
